mod_exp_ctrl: RTL and testbench

- Modular-exponentiation sequencer for the RSA datapath: computes R = B^E mod N by right-to-left binary square-and-multiply.
- Sits directly upstream of the shared `mod` reduction unit. It forms each W×W product internally and hands the (2W+1)-bit product to `mod` over a go/done handshake, then consumes the remainder `mod` returns.
- Top-level encrypt/decrypt logic drives it with (message, key exponent, modulus).

---
 rtl/mod_exp_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: modular-exponentiation sequencer, R = B^E mod N, computed by
// right-to-left binary square-and-multiply. Every reduction goes to an
// external shared `mod` unit over a four-phase go/done handshake.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   go                 start request (level, sampled only in IDLE)
//   base/exponent/modulus  B, E, N operands, captured when go is accepted
//   result, done, err  R (valid while done=1), completion, N=0 error flag
//   busy               high from go acceptance until done asserts
//   mod_x/mod_y/mod_go dividend, divisor and request to `mod`
//   mod_m/mod_done     remainder and completion from `mod`
//   op_count           (only with MODEXP_OP_COUNT_EN) count of completed
//                      `mod` handshakes in the current/last run
//
// Optional feature macro: MODEXP_OP_COUNT_EN
//
// state | meaning
// IDLE  | waiting for go
// RED   | set up the initial reduction b = B mod N
// STEP  | examine e: finish, multiply or square
// MUL   | set up acc*b
// SQR   | shift e, set up b*b unless e has run out
// REQ   | wait for mod_done low, then raise mod_go
// WAIT  | hold request until mod_done, latch remainder
// FIN   | done held until go drops
module mod_exp_ctrl #(
    parameter int W  = 32,
    parameter int MW = 2*W+1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          go,
    input  logic [W-1:0]  base,
    input  logic [W-1:0]  exponent,
    input  logic [W-1:0]  modulus,
    output logic [W-1:0]  result,
    output logic          done,
    output logic          busy,
    output logic          err,
`ifdef MODEXP_OP_COUNT_EN
    output logic [15:0]   op_count,
`endif
    output logic [MW-1:0] mod_x,
    output logic [MW-1:0] mod_y,
    output logic          mod_go,
    input  logic [MW-1:0] mod_m,
    input  logic          mod_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_RED, S_STEP, S_MUL, S_SQR, S_REQ, S_WAIT, S_FIN
    } state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    acc, acc_nxt, b, b_nxt, e, e_nxt, n, n_nxt;
    logic [W-1:0]    result_nxt;
    logic            done_nxt, busy_nxt, err_nxt, mod_go_nxt;
    logic [MW-1:0]   mod_x_nxt, mod_y_nxt;
    // Destination of the pending remainder: 1 = acc (multiply), 0 = b.
    logic            dst_acc, dst_acc_nxt;
    logic [W-1:0]    mul_lhs, e_shr;
    logic [2*W-1:0]  prod;
    logic            unused_mod_m_hi;
`ifdef MODEXP_OP_COUNT_EN
    logic [15:0]     op_count_nxt;
`endif

    // One shared W x W multiplier: acc*b in MUL, b*b otherwise.
    assign mul_lhs = (state == S_MUL) ? acc : b;
    assign prod    = (2*W)'(mul_lhs) * (2*W)'(b);
    assign e_shr   = e >> 1;
    // Remainder is always < N, so only the low W bits carry information.
    assign unused_mod_m_hi = ^mod_m[MW-1:W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            acc     <= '0;
            b       <= '0;
            e       <= '0;
            n       <= '0;
            dst_acc <= 1'b0;
            result  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            mod_go  <= 1'b0;
            mod_x   <= '0;
            mod_y   <= '0;
`ifdef MODEXP_OP_COUNT_EN
            op_count <= '0;
`endif
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            b       <= b_nxt;
            e       <= e_nxt;
            n       <= n_nxt;
            dst_acc <= dst_acc_nxt;
            result  <= result_nxt;
            done    <= done_nxt;
            busy    <= busy_nxt;
            err     <= err_nxt;
            mod_go  <= mod_go_nxt;
            mod_x   <= mod_x_nxt;
            mod_y   <= mod_y_nxt;
`ifdef MODEXP_OP_COUNT_EN
            op_count <= op_count_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        b_nxt       = b;
        e_nxt       = e;
        n_nxt       = n;
        dst_acc_nxt = dst_acc;
        result_nxt  = result;
        done_nxt    = done;
        busy_nxt    = busy;
        err_nxt     = err;
        mod_go_nxt  = mod_go;
        mod_x_nxt   = mod_x;
        mod_y_nxt   = mod_y;
`ifdef MODEXP_OP_COUNT_EN
        op_count_nxt = op_count;
`endif
        case (state)
            S_IDLE: begin
                if (go) begin
                    b_nxt    = base;
                    e_nxt    = exponent;
                    n_nxt    = modulus;
                    busy_nxt = 1'b1;
`ifdef MODEXP_OP_COUNT_EN
                    op_count_nxt = '0;
`endif
                    if (modulus == '0) begin
                        err_nxt    = 1'b1;
                        result_nxt = '0;
                        state_nxt  = S_FIN;
                    end else if (modulus == W'(1)) begin
                        result_nxt = '0;
                        state_nxt  = S_FIN;
                    end else begin
                        acc_nxt   = W'(1);
                        state_nxt = S_RED;
                    end
                end
            end
            S_RED: begin
                mod_x_nxt   = MW'(b);
                mod_y_nxt   = MW'(n);
                dst_acc_nxt = 1'b0;
                state_nxt   = S_REQ;
            end
            S_STEP: begin
                if (e == '0) begin
                    result_nxt = acc;
                    state_nxt  = S_FIN;
                end else if (e[0]) begin
                    state_nxt = S_MUL;
                end else begin
                    state_nxt = S_SQR;
                end
            end
            S_MUL: begin
                mod_x_nxt   = MW'(prod);
                mod_y_nxt   = MW'(n);
                dst_acc_nxt = 1'b1;
                state_nxt   = S_REQ;
            end
            S_SQR: begin
                e_nxt = e_shr;
                // The square after the top bit would never be used.
                if (e_shr == '0) begin
                    state_nxt = S_STEP;
                end else begin
                    mod_x_nxt   = MW'(prod);
                    mod_y_nxt   = MW'(n);
                    dst_acc_nxt = 1'b0;
                    state_nxt   = S_REQ;
                end
            end
            S_REQ: begin
                // Four-phase: previous mod_done must have fallen first.
                if (!mod_done) begin
                    mod_go_nxt = 1'b1;
                    state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mod_done) begin
                    mod_go_nxt = 1'b0;
`ifdef MODEXP_OP_COUNT_EN
                    op_count_nxt = op_count + 16'd1;
`endif
                    if (dst_acc) begin
                        acc_nxt   = mod_m[W-1:0];
                        state_nxt = S_SQR;
                    end else begin
                        b_nxt     = mod_m[W-1:0];
                        state_nxt = S_STEP;
                    end
                end
            end
            S_FIN: begin
                done_nxt = 1'b1;
                busy_nxt = 1'b0;
                // Only leave once done has been visible for at least a cycle.
                if (done && !go) begin
                    done_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
module tb_mod_exp_ctrl;
    localparam int W  = 32;
    localparam int MW = 2*W+1;

    logic          clk = 1'b0;
    logic          rst_n, go;
    logic [W-1:0]  base, exponent, modulus, result;
    logic          done, busy, err, mod_go, mod_done;
    logic [MW-1:0] mod_x, mod_y, mod_m;
`ifdef MODEXP_OP_COUNT_EN
    logic [15:0]   op_count;
`endif

    int passed = 0;
    int total  = 0;
    int req_cnt = 0;
    int proto_err = 0;
    int req_base;
    bit ok;

    always #5 clk = ~clk;

    mod_exp_ctrl #(.W(W), .MW(MW)) dut (
        .clk(clk), .rst_n(rst_n), .go(go),
        .base(base), .exponent(exponent), .modulus(modulus),
        .result(result), .done(done), .busy(busy), .err(err),
`ifdef MODEXP_OP_COUNT_EN
        .op_count(op_count),
`endif
        .mod_x(mod_x), .mod_y(mod_y), .mod_go(mod_go),
        .mod_m(mod_m), .mod_done(mod_done)
    );

    // Stub `mod` unit: random response latency, random delay of mod_done fall,
    // plus protocol monitoring of the request side.
    int            ph, cnt;
    logic          prev_go;
    logic [MW-1:0] prev_x, prev_y;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0; cnt = 0; mod_done = 1'b0; mod_m = '0; prev_go = 1'b0;
            prev_x = '0; prev_y = '0;
        end else begin
            if (mod_go && !prev_go) begin
                req_cnt++;
                if (mod_done) proto_err++;
            end
            if (mod_go && prev_go && (mod_x !== prev_x || mod_y !== prev_y))
                proto_err++;
            prev_go = mod_go; prev_x = mod_x; prev_y = mod_y;
            case (ph)
                0: if (mod_go) begin cnt = $urandom_range(1, 20); ph = 1; end
                1: begin
                    if (cnt <= 1) begin
                        mod_m = mod_x % mod_y; mod_done = 1'b1; ph = 2;
                    end else cnt--;
                end
                2: if (!mod_go) begin cnt = $urandom_range(0, 5); ph = 3; end
                default: begin
                    if (cnt == 0) begin mod_done = 1'b0; ph = 0; end
                    else cnt--;
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start(input logic [W-1:0] b_, input logic [W-1:0] e_, input logic [W-1:0] n_);
        @(negedge clk);
        base = b_; exponent = e_; modulus = n_; go = 1'b1;
        req_base = req_cnt;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
        end
    endtask

    task automatic finish_run(input string tag);
        go = 1'b0;
        @(negedge clk);
        chk({tag, " done drop"}, 64'(done), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; go = 1'b0; base = '0; exponent = '0; modulus = '0;
        repeat (3) @(negedge clk);
        chk("rst result", 64'(result), 64'd0);
        chk("rst done",   64'(done),   64'd0);
        chk("rst busy",   64'(busy),   64'd0);
        chk("rst err",    64'(err),    64'd0);
        chk("rst mod_go", 64'(mod_go), 64'd0);
        chk("rst mod_x",  64'(mod_x),  64'd0);
        chk("rst mod_y",  64'(mod_y),  64'd0);
        rst_n = 1'b1;

        // 4^13 mod 497 = 445, 1 + 3 + 3 = 7 requests
        start(32'd4, 32'd13, 32'd497);
        @(negedge clk);
        chk("r1 busy", 64'(busy), 64'd1);
        wait_done(ok);
        chk("r1 done", 64'(ok), 64'd1);
        chk("r1 result", 64'(result), 64'd445);
        chk("r1 err", 64'(err), 64'd0);
        chk("r1 reqs", 64'(req_cnt - req_base), 64'd7);
`ifdef MODEXP_OP_COUNT_EN
        chk("r1 op_count", 64'(op_count), 64'd7);
`endif
        finish_run("r1");

        // E=0: result 1 after a single reduction request
        start(32'd3, 32'd0, 32'd7);
        wait_done(ok);
        chk("r2 done", 64'(ok), 64'd1);
        chk("r2 result", 64'(result), 64'd1);
        chk("r2 reqs", 64'(req_cnt - req_base), 64'd1);
        finish_run("r2");

        // 2^10 mod 1000 = 24, 1 + 2 + 3 = 6 requests
        start(32'd2, 32'd10, 32'd1000);
        wait_done(ok);
        chk("r3 done", 64'(ok), 64'd1);
        chk("r3 result", 64'(result), 64'd24);
        chk("r3 reqs", 64'(req_cnt - req_base), 64'd6);
        finish_run("r3");

        // N=1: result 0, no request
        start(32'd5, 32'd9, 32'd1);
        wait_done(ok);
        chk("n1 done", 64'(ok), 64'd1);
        chk("n1 result", 64'(result), 64'd0);
        chk("n1 err", 64'(err), 64'd0);
        chk("n1 reqs", 64'(req_cnt - req_base), 64'd0);
        finish_run("n1");

        // N=0: err with done
        start(32'd5, 32'd9, 32'd0);
        wait_done(ok);
        chk("n0 done", 64'(ok), 64'd1);
        chk("n0 err", 64'(err), 64'd1);
        chk("n0 result", 64'(result), 64'd0);
        chk("n0 reqs", 64'(req_cnt - req_base), 64'd0);
        finish_run("n0");
        chk("n0 err drop", 64'(err), 64'd0);

        // N = 2^32-5 is prime, E = (N-1)+5, B mod N = 4 -> 4^5 = 1024
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        wait_done(ok);
        chk("big done", 64'(ok), 64'd1);
        chk("big result", 64'(result), 64'd1024);
        chk("big reqs", 64'(req_cnt - req_base), 64'd64);
        finish_run("big");
        chk("protocol", 64'(proto_err), 64'd0);

        // Reset during the first multiply request (second request of the run)
        start(32'd4, 32'd13, 32'd497);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (req_cnt - req_base >= 2) break;
        end
        chk("mid mod_go", 64'(mod_go), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async mod_go", 64'(mod_go), 64'd0);
        chk("async busy", 64'(busy), 64'd0);
        chk("async done", 64'(done), 64'd0);
        go = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start(32'd4, 32'd13, 32'd497);
        wait_done(ok);
        chk("post-rst done", 64'(ok), 64'd1);
        chk("post-rst result", 64'(result), 64'd445);
        finish_run("post-rst");

        // go held through done; inputs changed mid-run
        start(32'd2, 32'd10, 32'd1000);
        @(negedge clk);
        base = 32'd3; exponent = 32'd0; modulus = 32'd7;
        wait_done(ok);
        chk("hold done", 64'(ok), 64'd1);
        chk("hold result", 64'(result), 64'd24);
        repeat (10) @(negedge clk);
        chk("hold done kept", 64'(done), 64'd1);
        chk("hold busy", 64'(busy), 64'd0);
        chk("hold reqs", 64'(req_cnt - req_base), 64'd6);
        finish_run("hold");
        chk("hold result kept", 64'(result), 64'd24);
        start(32'd3, 32'd0, 32'd7);
        wait_done(ok);
        chk("fresh done", 64'(ok), 64'd1);
        chk("fresh result", 64'(result), 64'd1);
        chk("fresh reqs", 64'(req_cnt - req_base), 64'd1);
        finish_run("fresh");
        chk("protocol final", 64'(proto_err), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
